// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared op codes, FSM encoding and address helpers for the internal RAM initiator
package ram_pkg;

  localparam logic [2:0] OP_RD_DIR = 3'd0;
  localparam logic [2:0] OP_WR_DIR = 3'd1;
  localparam logic [2:0] OP_RD_IND = 3'd2;
  localparam logic [2:0] OP_WR_IND = 3'd3;
  localparam logic [2:0] OP_RD_BIT = 3'd4;
  localparam logic [2:0] OP_WR_BIT = 3'd5;
  localparam logic [2:0] OP_PUSH   = 3'd6;
  localparam logic [2:0] OP_POP    = 3'd7;

  localparam logic [7:0] BIT_AREA_BASE = 8'h20;
  localparam logic [7:0] SFR_BASE      = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PTR,
    ST_PTR_CAP,
    ST_ACC,
    ST_RESP
  } state_t;

  // Byte address of R0/R1 in the selected register bank (bank*8 + i)
  function automatic logic [7:0] bank_addr(input logic [1:0] rs, input logic sel);
    return {3'b000, rs, 2'b00, sel};
  endfunction

endpackage

// File: rtl/bit_addr_decode.sv
// rtl/bit_addr_decode.sv - maps an 8051 bit address onto a RAM byte address and bit selector
module bit_addr_decode
  import ram_pkg::*;
(
  input  logic [7:0] bit_addr,
  output logic [7:0] byte_addr,
  output logic [7:0] bit_sel
);

  // Low bit space lives in the 20h..2Fh bit area; high bit space is the bit-addressable SFRs
  always_comb begin
    if (bit_addr < SFR_BASE) begin
      byte_addr = BIT_AREA_BASE + {4'b0000, bit_addr[6:3]};
      bit_sel   = bit_addr;
    end else begin
      byte_addr = {bit_addr[7:3], 3'b000};
      bit_sel   = {5'b00000, bit_addr[2:0]};
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - 8051 internal data memory initiator: addressing-mode resolution and RAM strobe sequencing
module ram_access_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_wbit,
  input  logic [1:0]            psw_rs,
  input  logic [ADDR_WIDTH-1:0] sp_in,
  output logic [ADDR_WIDTH-1:0] sp_out,
  output logic                  sp_we,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_bit,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rd,
  output logic                  ram_wr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_in_bit,
  output logic [ADDR_WIDTH-1:0] ram_bit_addr,
  output logic                  ram_is_bit,
  output logic                  ram_indirect,
  input  logic [DATA_WIDTH-1:0] ram_out,
  input  logic                  ram_out_bit
);

  state_t                  state, next_state;
  logic [2:0]              op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    wbit_q;
  logic [1:0]              rs_q;
  logic [ADDR_WIDTH-1:0]   sp_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    rsp_bit_q;

  logic                    is_read;
  logic [ADDR_WIDTH-1:0]   sp_inc, sp_dec;
  logic [ADDR_WIDTH-1:0]   bit_byte_addr, bit_sel;

  assign is_read = (op_q == OP_RD_DIR) || (op_q == OP_RD_IND) ||
                   (op_q == OP_RD_BIT) || (op_q == OP_POP);
  assign sp_inc  = sp_q + 8'd1;
  assign sp_dec  = sp_q - 8'd1;

  bit_addr_decode u_bit_decode (
    .bit_addr  (addr_q),
    .byte_addr (bit_byte_addr),
    .bit_sel   (bit_sel)
  );

  // State register plus request latch, pointer capture and held read response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wbit_q     <= 1'b0;
      rs_q       <= '0;
      sp_q       <= '0;
      ptr_q      <= '0;
      rsp_data_q <= '0;
      rsp_bit_q  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wbit_q  <= req_wbit;
        rs_q    <= psw_rs;
        sp_q    <= sp_in;
      end
      if (state == ST_PTR_CAP) begin
        ptr_q <= ram_out;
      end
      if (state == ST_RESP && is_read) begin
        rsp_data_q <= ram_out;
        rsp_bit_q  <= ram_out_bit;
      end
    end
  end

  // Next-state and per-state RAM port / response drive
  always_comb begin
    next_state   = state;
    req_ready    = 1'b0;
    sp_out       = '0;
    sp_we        = 1'b0;
    rsp_valid    = 1'b0;
    rsp_data     = rsp_data_q;
    rsp_bit      = rsp_bit_q;
    ram_addr     = '0;
    ram_rd       = 1'b0;
    ram_wr       = 1'b0;
    ram_wdata    = '0;
    ram_in_bit   = 1'b0;
    ram_bit_addr = '0;
    ram_is_bit   = 1'b0;
    ram_indirect = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          next_state = (req_op == OP_RD_IND || req_op == OP_WR_IND) ? ST_PTR : ST_ACC;
        end
      end
      ST_PTR: begin
        ram_rd     = 1'b1;
        ram_addr   = bank_addr(rs_q, addr_q[0]);
        next_state = ST_PTR_CAP;
      end
      ST_PTR_CAP: begin
        next_state = ST_ACC;
      end
      ST_ACC: begin
        ram_rd     = is_read;
        ram_wr     = !is_read;
        ram_wdata  = wdata_q;
        next_state = ST_RESP;
        case (op_q)
          OP_RD_IND, OP_WR_IND: begin
            ram_addr     = ptr_q;
            ram_indirect = ptr_q[7];
          end
          OP_RD_BIT, OP_WR_BIT: begin
            ram_addr     = bit_byte_addr;
            ram_bit_addr = bit_sel;
            ram_is_bit   = 1'b1;
            ram_in_bit   = (op_q == OP_WR_BIT) ? wbit_q : 1'b0;
          end
          OP_PUSH: begin
            ram_addr     = sp_inc;
            ram_indirect = sp_inc[7];
            sp_out       = sp_inc;
            sp_we        = 1'b1;
          end
          OP_POP: begin
            ram_addr     = sp_q;
            ram_indirect = sp_q[7];
            sp_out       = sp_dec;
            sp_we        = 1'b1;
          end
          default: begin
            ram_addr = addr_q;
          end
        endcase
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        next_state = ST_IDLE;
        if (is_read) begin
          rsp_data = ram_out;
          rsp_bit  = ram_out_bit;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule
